// File: rtl/dmem_responder.sv
// Single-port data memory that answers one CPU load/store at a time after a fixed LATENCY.
// Faulted (misaligned or out-of-range) requests still respond, with addr_err set and no write.
module dmem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept_s;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  fire_s;
    logic                  err_s;
    logic                  wr_en_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [31:0]           rdata_d;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_rdata_q;
    logic                  addr_err_q;
    logic [31:0]           mem_q [DEPTH];

    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Next-state and wait-counter logic of the request sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    cnt_d    = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The memory access happens on the edge that leaves RESP, so the registered
    // response and the store both land on edge T+LATENCY.
    assign fire_s  = (state_q == ST_RESP);
    assign err_s   = addr_fault(addr_q);
    assign idx_s   = addr_q[DEPTH_LOG2+1:2];
    assign wr_en_s = fire_s && we_q && !err_s;

    // Load data for the response register; zero for stores, faults and idle cycles.
    always_comb begin
        rdata_d = 32'd0;
        if (fire_s && !we_q && !err_s) begin
            rdata_d = mem_q[idx_s];
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Sequencer state and captured request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_s) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
        end
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            addr_err_q   <= 1'b0;
        end else begin
            ready_q      <= (state_d == ST_IDLE);
            resp_valid_q <= fire_s;
            resp_rdata_q <= rdata_d;
            addr_err_q   <= fire_s && err_s;
        end
    end

    // Word storage with per-byte write enables; cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            mem_q[idx_s] <= merge_bytes(mem_q[idx_s], wdata_q, be_q);
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a LATENCY=2 instance checked against an array
// model of the memory, plus a LATENCY=1 instance for short-latency timing.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, addr_err;
    logic [31:0] resp_rdata;

    logic        l1_valid, l1_we;
    logic [31:0] l1_addr, l1_wdata;
    logic [3:0]  l1_be;
    logic        l1_ready, l1_resp_valid, l1_err;
    logic [31:0] l1_rdata;

    logic [31:0] mem_m [0:1023];
    int          errors;
    int          checks;

    dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(10)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .addr_err(addr_err)
    );

    dmem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(l1_valid), .req_we(l1_we), .req_addr(l1_addr),
        .req_be(l1_be), .req_wdata(l1_wdata),
        .req_ready(l1_ready), .resp_valid(l1_resp_valid),
        .resp_rdata(l1_rdata), .addr_err(l1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word array of 1024 entries, byte-addressed, faults never write.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata,
                               output logic [31:0] exp_rdata, output logic exp_err);
        int unsigned w;
        exp_err   = ((addr % 4) != 0) || (addr >= 32'd4096);
        w         = addr / 4;
        exp_rdata = 32'd0;
        if (!exp_err) begin
            if (!we) begin
                exp_rdata = mem_m[w[9:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[w[9:0]][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
    endtask

    // One request on the LATENCY=2 instance with full timing and data checks.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input bit sync, input string name);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;
        bit          seen;
        model_apply(we, addr, be, wdata, exp_rd, exp_er);
        if (sync) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_be = 4'($urandom); req_wdata = $urandom;
        cyc  = 0;
        seen = 1'b0;
        while (cyc <= 20) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (req_ready !== 1'b0 || resp_rdata !== 32'd0 || addr_err !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_cycle%0d: got ready=%b rdata=%h err=%b expected 0/0/0",
                         name, cyc, req_ready, resp_rdata, addr_err);
            end
            cyc++;
        end
        checks++;
        if (!seen || cyc != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%b) expected %0d", name, cyc, seen, LAT);
        end
        if (seen) begin
            checks++;
            if (resp_rdata !== exp_rd || addr_err !== exp_er) begin
                errors++;
                $display("FAIL %s response: got rdata=%h err=%b expected rdata=%h err=%b",
                         name, resp_rdata, addr_err, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || addr_err !== 1'b0 ||
            l1_ready !== 1'b1 || l1_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b l1_ready=%b l1_valid=%b expected 1/0/0/0/1/0",
                     req_ready, resp_valid, resp_rdata, addr_err, l1_ready, l1_resp_valid);
        end
        model_clear();
        reset = 1'b0;
        do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, "first_store");
    endtask

    task automatic test_store_load();
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, "load_full");
        do_req(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1'b1, "byte_store");
        do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, "load_byte_merged");
        do_req(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b1, "store_be0");
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, "load_after_be0");
    endtask

    task automatic test_addr_err();
        do_req(1'b0, 32'h13, 4'hF, 32'h0, 1'b1, "load_misaligned");
        do_req(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, "load_out_of_range");
        do_req(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1, "store_out_of_range");
        do_req(1'b1, 32'h11, 4'hF, 32'h12121212, 1'b1, "store_misaligned");
        do_req(1'b0, 32'h0, 4'hF, 32'h0, 1'b1, "load_alias_word0");
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, "load_after_faults");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        logic        exp_er;
        logic        rdy;
        logic        q_we [$];
        logic [31:0] q_addr [$];
        logic [3:0]  q_be [$];
        logic [31:0] q_wd [$];
        for (int i = 0; i <= 15; i++) begin
            @(negedge clk);
            rdy = req_ready;
            checks++;
            if (rdy !== ((i % 3) == 0)) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b expected %b", i, rdy, ((i % 3) == 0));
            end
            checks++;
            if (resp_valid !== (i > 0 && (i % 3) == 0)) begin
                errors++;
                $display("FAIL b2b_valid%0d: got %b expected %b", i, resp_valid, (i > 0 && (i % 3) == 0));
            end
            if (resp_valid === 1'b1 && q_we.size() > 0) begin
                model_apply(q_we.pop_front(), q_addr.pop_front(), q_be.pop_front(),
                            q_wd.pop_front(), exp_rd, exp_er);
                checks++;
                if (resp_rdata !== exp_rd || addr_err !== exp_er) begin
                    errors++;
                    $display("FAIL b2b_resp%0d: got rdata=%h err=%b expected rdata=%h err=%b",
                             i, resp_rdata, addr_err, exp_rd, exp_er);
                end
            end
            if (i < 15) begin
                req_valid = 1'b1;
                req_we    = 1'($urandom);
                req_addr  = ($urandom % 8) * 4 + ((($urandom % 6) == 0) ? 32'd2 : 32'd0);
                req_be    = 4'($urandom);
                req_wdata = $urandom;
                if (rdy === 1'b1) begin
                    q_we.push_back(req_we); q_addr.push_back(req_addr);
                    q_be.push_back(req_be); q_wd.push_back(req_wdata);
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        checks++;
        if (q_we.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending expected 0", q_we.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom % 10;
            if (r < 7)       a = ($urandom % 8) * 4;
            else if (r == 7) a = ($urandom % 8) * 4 + 1 + ($urandom % 3);
            else if (r == 8) a = 32'h1000 + ($urandom % 4) * 4;
            else             a = $urandom;
            do_req(1'($urandom), a, 4'($urandom), $urandom, 1'b1, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got ready=%b valid=%b rdata=%h err=%b expected 1/0/0/0",
                     req_ready, resp_valid, resp_rdata, addr_err);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_resp%0d: got %b expected 0", i, resp_valid);
            end
        end
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, "load_after_abort");
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, "load_mem_cleared");
    endtask

    // One request on the LATENCY=1 instance; response expected one edge after acceptance.
    task automatic l1_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input string name);
        @(negedge clk);
        checks++;
        if (l1_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, l1_ready);
        end
        l1_valid = 1'b1; l1_we = we; l1_addr = addr; l1_be = be; l1_wdata = wdata;
        @(posedge clk);
        #1;
        l1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (l1_resp_valid !== 1'b0 || l1_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle_T: got valid=%b ready=%b expected 0/0", name, l1_resp_valid, l1_ready);
        end
        @(negedge clk);
        checks++;
        if (l1_resp_valid !== 1'b1 || l1_rdata !== exp_rd || l1_err !== 1'b0 || l1_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cycle_T1: got valid=%b rdata=%h err=%b ready=%b expected 1/%h/0/1",
                     name, l1_resp_valid, l1_rdata, l1_err, l1_ready, exp_rd);
        end
    endtask

    task automatic test_latency1();
        l1_req(1'b0, 32'h04, 4'hF, 32'h0, 32'h0, "l1_load_reset");
        l1_req(1'b1, 32'h04, 4'hF, 32'hA5A51234, 32'h0, "l1_store");
        l1_req(1'b0, 32'h04, 4'hF, 32'h0, 32'hA5A51234, "l1_load");
        l1_req(1'b1, 32'h04, 4'b1000, 32'h11000000, 32'h0, "l1_byte_store");
        l1_req(1'b0, 32'h04, 4'h0, 32'h0, 32'h11A51234, "l1_load_merged");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_be = 4'd0; req_wdata = 32'd0;
        l1_valid = 1'b0; l1_we = 1'b0; l1_addr = 32'd0; l1_be = 4'd0; l1_wdata = 32'd0;
        test_reset();
        test_store_load();
        test_addr_err();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
